// File: rtl/cla_seq_adder64_if.sv
// Operand/result bundle for the sequential slice adder.
// Latency: none (wires only); producer drives operands, adder drives results.
// Backpressure: busy high means start is ignored; done pulses once per result.
interface cla_seq_adder64_if #(
  parameter int NSLICE = 4
) ();
  localparam int W = 16 * NSLICE;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carryInput;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryOutput;
  logic         overflow;

  // Operand producer side.
  modport master (
    output start, sub, a, b, carryInput,
    input  busy, done, sum, carryOutput, overflow
  );

  // Adder side.
  modport slave (
    input  start, sub, a, b, carryInput,
    output busy, done, sum, carryOutput, overflow
  );
endinterface

// File: rtl/cla_seq_adder64.sv
// Wide add/subtract built from one shared 16-bit carry-lookahead adder, one slice per cycle.
// Latency: start edge E0, slices written E1..E(NSLICE), done for one cycle after E(NSLICE).
// Backpressure: start is ignored while busy; a start during done chains a new operation.

// 16-bit two-level carry-lookahead adder: four 4-bit groups plus a group-carry layer.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        prop,
  output logic        gene
);
  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  // Group propagate/generate, group carries, then per-bit carries inside each group.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;

    for (int j = 0; j < 4; j++) begin
      gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end

    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end

    sum  = p ^ c;
    cout = gc[4];
    prop = &gp;
    gene = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
         | (gp[3] & gp[2] & gp[1] & gg[0]);
  end
endmodule

module cla_seq_adder64 #(
  parameter int NSLICE = 4
) (
  input  logic               clk,
  input  logic               rst,
  cla_seq_adder64_if.slave   bus
);
  localparam int W     = 16 * NSLICE;
  localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             c_reg;
  logic [IDX_W-1:0] idx;
  logic             a_msb;
  logic             b_msb;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic             ovf_q;

  logic             accept;
  logic             last;
  logic             busy_c;
  logic             done_c;
  logic [15:0]      slice_a;
  logic [15:0]      slice_b;
  logic [15:0]      slice_sum;
  logic             slice_cout;
  logic             cla_prop;
  logic             cla_gene;
  logic             unused_cla;

  // The shared adder's lookahead outputs are not needed at this level.
  assign unused_cla = cla_prop | cla_gene;

  assign last = (idx == IDX_W'(NSLICE - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: DONE can chain straight into RUN so back-to-back ops cost NSLICE+1 cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs and start acceptance; start is only honoured outside RUN.
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    accept = 1'b0;
    case (state)
      IDLE: accept = bus.start;
      RUN:  busy_c = 1'b1;
      DONE: begin
        done_c = 1'b1;
        accept = bus.start;
      end
      default: ;
    endcase
  end

  // Select the current operand slices for the shared adder.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (idx == IDX_W'(s)) begin
        slice_a = op_a[16*s +: 16];
        slice_b = op_b[16*s +: 16];
      end
    end
  end

  cla16 u_cla16 (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (c_reg),
    .sum  (slice_sum),
    .cout (slice_cout),
    .prop (cla_prop),
    .gene (cla_gene)
  );

  // Operand latch on accept; in RUN write one result slice per edge and ripple the carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      c_reg   <= 1'b0;
      idx     <= '0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1, so the inverted operand and forced carry are latched here.
      op_a  <= bus.a;
      op_b  <= bus.sub ? ~bus.b : bus.b;
      c_reg <= bus.sub ? 1'b1 : bus.carryInput;
      idx   <= '0;
      a_msb <= bus.a[W-1];
      b_msb <= bus.sub ? ~bus.b[W-1] : bus.b[W-1];
    end else if (state == RUN) begin
      for (int s = 0; s < NSLICE; s++) begin
        if (idx == IDX_W'(s)) begin
          sum_q[16*s +: 16] <= slice_sum;
        end
      end
      c_reg <= slice_cout;
      idx   <= idx + IDX_W'(1);
      if (last) begin
        carry_q <= slice_cout;
        ovf_q   <= (a_msb == b_msb) && (slice_sum[15] != a_msb);
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.sum         = sum_q;
  assign bus.carryOutput = carry_q;
  assign bus.overflow    = ovf_q;
endmodule
